// File: rtl/alu_types_pkg.sv
// Shared ALU types and sizing constants for the ALU and its result FIFO.
package alu_types_pkg;

  localparam int ALU_WIDTH      = 6;
  localparam int ALU_FIFO_DEPTH = 8;
  localparam int ALU_AF_LEVEL   = 6;
  localparam int ALU_DROP_W     = 8;

  // ALU result is one bit wider than the operands to hold the carry.
  typedef logic [ALU_WIDTH:0] alu_result_t;

endpackage

// File: rtl/alu_result_fifo_if.sv
// Bus between the ALU output registers, the result FIFO and the result consumer.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface alu_result_fifo_if
  import alu_types_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int DEPTH  = ALU_FIFO_DEPTH,
  parameter int DROP_W = ALU_DROP_W
);

  logic [WIDTH:0]           in_data;
  logic                     in_valid;
  logic [WIDTH:0]           out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     almost_full;
  logic                     overflow;
  logic [DROP_W-1:0]        drop_cnt;
  logic                     clr_ovf;

  modport slave (
    input  in_data, in_valid, out_ready, clr_ovf,
    output out_data, out_valid, count, almost_full, overflow, drop_cnt
  );

  modport master (
    output in_data, in_valid, out_ready, clr_ovf,
    input  out_data, out_valid, count, almost_full, overflow, drop_cnt
  );

endinterface

// File: rtl/alu_fifo_mem.sv
// Storage array for the ALU result FIFO: synchronous write, asynchronous read, no reset.
module alu_fifo_mem
  import alu_types_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = ALU_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_wrAddr,
  input  logic [WIDTH:0]           i_wrData,
  input  logic [$clog2(DEPTH)-1:0] i_rdAddr,
  output logic [WIDTH:0]           o_rdData
);

  logic [WIDTH:0] r_mem [DEPTH];

  // Write the accepted entry into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/alu_result_fifo.sv
// Result FIFO behind the ALU: absorbs bursts of results that cannot be stalled,
// presents them over valid/ready, and counts any result dropped while full.
module alu_result_fifo
  import alu_types_pkg::*;
#(
  parameter int WIDTH    = ALU_WIDTH,
  parameter int DEPTH    = ALU_FIFO_DEPTH,
  parameter int AF_LEVEL = ALU_AF_LEVEL,
  parameter int DROP_W   = ALU_DROP_W
) (
  input logic               clk,
  input logic               rst_n,
  alu_result_fifo_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     r_wrPtr;
  logic [PW-1:0]     r_rdPtr;
  logic [CW-1:0]     r_count;
  logic              r_outValid;
  logic              r_almostFull;
  logic              r_overflow;
  logic [DROP_W-1:0] r_dropCnt;

  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [CW-1:0]     w_countNext;
  logic [WIDTH:0]    w_rdData;

  // A full FIFO can still take a result when the head leaves in the same cycle.
  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = r_outValid & bus.out_ready;
  assign w_push = bus.in_valid & (~w_full | w_pop);
  assign w_drop = bus.in_valid & w_full & ~w_pop;

  // Occupancy after this cycle; flags are registered from it so inputs never reach outputs combinationally.
  always_comb begin
    w_countNext = r_count;
    if (w_push && !w_pop) begin
      w_countNext = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_countNext = r_count - CW'(1);
    end
  end

  // Pointers, occupancy and the registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_count      <= '0;
      r_outValid   <= 1'b0;
      r_almostFull <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      r_count      <= w_countNext;
      r_outValid   <= (w_countNext != '0);
      r_almostFull <= (w_countNext >= CW'(AF_LEVEL));
    end
  end

  // Sticky overflow and saturating drop counter; a clear in the same cycle as a drop wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_dropCnt  <= '0;
    end else if (bus.clr_ovf) begin
      r_overflow <= 1'b0;
      r_dropCnt  <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_dropCnt != '1) begin
        r_dropCnt <= r_dropCnt + DROP_W'(1);
      end
    end
  end

  alu_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk      (clk),
    .i_we     (w_push),
    .i_wrAddr (r_wrPtr),
    .i_wrData (bus.in_data),
    .i_rdAddr (r_rdPtr),
    .o_rdData (w_rdData)
  );

  // Memory is never reset, so the head is masked to zero while empty.
  assign bus.out_data    = r_outValid ? w_rdData : '0;
  assign bus.out_valid   = r_outValid;
  assign bus.count       = r_count;
  assign bus.almost_full = r_almostFull;
  assign bus.overflow    = r_overflow;
  assign bus.drop_cnt    = r_dropCnt;

endmodule
